dff_pipe: RTL

- Parametrised successor to the single-bit D flip-flop: a WIDTH-bit, DEPTH-stage registered delay line.
- Adds a valid bit per stage, a global stall (en), a synchronous flush, and a registered occupancy count.
- Used wherever a data path needs N cycles of retiming with bubble tracking, e.g. aligning operands or delaying a strobe together with its payload.

---
 rtl/dff_pipe.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/dff_pipe.sv
// dff_pipe: WIDTH-bit, DEPTH-stage registered delay line with a valid bit per
// stage, a global stall (en), a synchronous flush and a registered occupancy.
// Data registers only load when the incoming valid is set, so q keeps the last
// valid payload while bubbles pass through.
// Optional feature macro: DFF_PIPE_PARITY_EN adds an even-parity bit per stage
// and a registered par_err output.
module dff_pipe #(
  parameter int                 WIDTH     = 8,
  parameter int                 DEPTH     = 4,
  parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        flush,
  input  logic [WIDTH-1:0]            d,
  input  logic                        d_vld,
  output logic [WIDTH-1:0]            q,
  output logic                        q_vld,
`ifdef DFF_PIPE_PARITY_EN
  output logic [$clog2(DEPTH+1)-1:0]  occ,
  output logic                        par_err
`else
  output logic [$clog2(DEPTH+1)-1:0]  occ
`endif
);

  localparam int OCCW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] data_q    [DEPTH];
  logic [WIDTH-1:0] data_d    [DEPTH];
  logic [WIDTH-1:0] in_data_s [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_d;
  logic [DEPTH-1:0] in_vld_s;
  logic [OCCW-1:0]  occ_q;
  logic [OCCW-1:0]  occ_d;

`ifdef DFF_PIPE_PARITY_EN
  logic [DEPTH-1:0] par_q;
  logic [DEPTH-1:0] par_d;
  logic [DEPTH-1:0] in_par_s;
  logic             par_err_q;
  logic             par_err_d;
  // Verification-only hook state: flips the parity captured into stage 0.
  logic             inj_flip_s = 1'b0;

  // Even-parity bit for one data word (XOR of all bits).
  function automatic logic even_par(input logic [WIDTH-1:0] w);
    even_par = ^w;
  endfunction

  // Corrupt the parity of the word captured at the next rising edge.
  task automatic inject_par_err();
    inj_flip_s = 1'b1;
    @(posedge clk);
    @(negedge clk);
    inj_flip_s = 1'b0;
  endtask
`endif

  // Per-stage inputs: stage 0 takes the port, stage i takes stage i-1.
  always_comb begin
    in_data_s[0] = d;
    in_vld_s[0]  = d_vld;
    for (int i = 1; i < DEPTH; i++) begin
      in_data_s[i] = data_q[i-1];
      in_vld_s[i]  = vld_q[i-1];
    end
  end

  // Next-state: flush clears valids, en advances, otherwise everything holds.
  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    occ_d  = occ_q;
    if (flush) begin
      vld_d = {DEPTH{1'b0}};
      occ_d = {OCCW{1'b0}};
    end else if (en) begin
      for (int i = 0; i < DEPTH; i++) begin
        vld_d[i] = in_vld_s[i];
        if (in_vld_s[i]) begin
          data_d[i] = in_data_s[i];
        end else begin
          data_d[i] = data_q[i];
        end
      end
      occ_d = occ_q + OCCW'(d_vld) - OCCW'(vld_q[DEPTH-1]);
    end else begin
      vld_d = vld_q;
      occ_d = occ_q;
    end
  end

  // Pipeline registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= RESET_VAL;
      end
      vld_q <= {DEPTH{1'b0}};
      occ_q <= {OCCW{1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
      end
      vld_q <= vld_d;
      occ_q <= occ_d;
    end
  end

`ifdef DFF_PIPE_PARITY_EN
  // Parity inputs per stage; stage 0 computes parity from d (plus the hook).
  always_comb begin
    in_par_s[0] = even_par(d) ^ inj_flip_s;
    for (int i = 1; i < DEPTH; i++) begin
      in_par_s[i] = par_q[i-1];
    end
  end

  // Parity bits follow exactly the same load rules as the data registers.
  always_comb begin
    par_d = par_q;
    if (flush) begin
      par_d = par_q;
    end else if (en) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (in_vld_s[i]) begin
          par_d[i] = in_par_s[i];
        end else begin
          par_d[i] = par_q[i];
        end
      end
    end else begin
      par_d = par_q;
    end
    par_err_d = vld_q[DEPTH-1] & (even_par(data_q[DEPTH-1]) != par_q[DEPTH-1]);
  end

  // Parity storage and registered parity error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      par_q     <= {DEPTH{1'b0}};
      par_err_q <= 1'b0;
    end else begin
      par_q     <= par_d;
      par_err_q <= par_err_d;
    end
  end

  assign par_err = par_err_q;
`endif

  assign q     = data_q[DEPTH-1];
  assign q_vld = vld_q[DEPTH-1];
  assign occ   = occ_q;

endmodule
